// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR XIFU pipeline control block.
package fir_xifu_pkg;

  localparam int X_ID_WIDTH = 4;
  localparam int X_ID_MAX   = 2 ** X_ID_WIDTH;

  // Lifecycle of one XIF ID slot.
  typedef enum logic [1:0] {
    FREE      = 2'b00,
    ISSUED    = 2'b01,
    COMMITTED = 2'b10,
    KILLED    = 2'b11
  } ctrl_state_t;

  // Issue pulse from the ID stage.
  typedef struct packed {
    logic                  issue;
    logic [X_ID_WIDTH-1:0] id;
  } id2ctrl_t;

  // Core XIF commit handshake bundled for the core wrapper.
  typedef struct packed {
    logic                  valid;
    logic [X_ID_WIDTH-1:0] id;
    logic                  kill;
  } commit_if_t;

  // Per-ID clear bitmap from WB.
  typedef struct packed {
    logic [X_ID_MAX-1:0] clear;
  } wb2ctrl_t;

  // Commit bitmap to EX.
  typedef struct packed {
    logic [X_ID_MAX-1:0] commit;
  } ctrl2ex_t;

  // Issue/commit/kill bitmaps to WB.
  typedef struct packed {
    logic [X_ID_MAX-1:0] issue;
    logic [X_ID_MAX-1:0] commit;
    logic [X_ID_MAX-1:0] kill;
  } ctrl2wb_t;

endpackage

// File: rtl/fir_xifu_ctrl_slot.sv
// One XIF ID slot: FREE -> ISSUED -> COMMITTED/KILLED -> FREE, with a sticky
// error flag for any event that is illegal in the current state.
module fir_xifu_ctrl_slot
  import fir_xifu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_i,
  input  logic        commit_i,
  input  logic        kill_i,
  input  logic        clear_i,
  output ctrl_state_t state_o,
  output logic        err_o
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  logic        r_err;
  logic        w_viol;
  ctrl_state_t w_commit_state;

  assign w_commit_state = kill_i ? KILLED : COMMITTED;

  // Next state from the state at the start of the cycle; an illegal event is
  // ignored (its own effect only) and flagged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next = r_state;
    w_viol = 1'b0;
    unique case (r_state)
      FREE: begin
        if (issue_i) begin
          // Same-cycle issue + commit/kill is legal.
          w_next = commit_i ? w_commit_state : ISSUED;
        end else if (commit_i) begin
          w_viol = 1'b1;
        end
        if (clear_i) w_viol = 1'b1;
      end
      ISSUED: begin
        if (issue_i || clear_i) w_viol = 1'b1;
        if (commit_i) w_next = w_commit_state;
      end
      COMMITTED, KILLED: begin
        if (issue_i || commit_i) w_viol = 1'b1;
        // A duplicate issue alongside a clear still lets the clear free the slot.
        if (clear_i) w_next = FREE;
      end
      default: w_next = FREE;
    endcase
  end

  // State register and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= FREE;
      r_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_next;
      r_err   <= r_err | w_viol;
    end
  end

  assign state_o = r_state;
  assign err_o   = r_err;

endmodule

// File: rtl/fir_xifu_ctrl.sv
// Per-ID tracker/scheduler: one slot FSM per XIF ID, one-hot event decode,
// bitmap outputs decoded from registered slot state.
module fir_xifu_ctrl
  import fir_xifu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  id2ctrl_t              id2ctrl_i,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  input  wb2ctrl_t              wb2ctrl_i,
  output ctrl2ex_t              ctrl2ex_o,
  output ctrl2wb_t              ctrl2wb_o,
  output logic [X_ID_MAX-1:0]   free_o,
  output logic                  full_o,
  output logic [X_ID_WIDTH:0]   outstanding_o,
  output logic                  err_o
);

  logic [X_ID_MAX-1:0] w_issue_hit;
  logic [X_ID_MAX-1:0] w_commit_hit;
  logic [X_ID_MAX-1:0] w_slot_err;
  ctrl_state_t         w_state [X_ID_MAX];
  logic [X_ID_WIDTH:0] w_count;

  for (genvar g = 0; g < X_ID_MAX; g++) begin : g_slot
    assign w_issue_hit[g]  = id2ctrl_i.issue && (id2ctrl_i.id == X_ID_WIDTH'(g));
    assign w_commit_hit[g] = commit_valid_i && (commit_id_i == X_ID_WIDTH'(g));

    fir_xifu_ctrl_slot u_slot (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .issue_i  (w_issue_hit[g]),
      .commit_i (w_commit_hit[g]),
      .kill_i   (commit_kill_i),
      .clear_i  (wb2ctrl_i.clear[g]),
      .state_o  (w_state[g]),
      .err_o    (w_slot_err[g])
    );

    assign ctrl2ex_o.commit[g] = (w_state[g] == COMMITTED);
    assign ctrl2wb_o.issue[g]  = (w_state[g] != FREE);
    assign ctrl2wb_o.commit[g] = (w_state[g] == COMMITTED);
    assign ctrl2wb_o.kill[g]   = (w_state[g] == KILLED);
    assign free_o[g]           = (w_state[g] == FREE);
  end

  // Count of occupied slots; one bit wider than the ID so 16 fits.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < X_ID_MAX; i++) begin
      w_count = w_count + {{X_ID_WIDTH{1'b0}}, ~free_o[i]};
    end
  end

  assign outstanding_o = w_count;
  assign full_o        = ~|free_o;
  assign err_o         = |w_slot_err;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Directed scoreboard bench for fir_xifu_ctrl.
module tb_fir_xifu_ctrl;
  import fir_xifu_pkg::*;

  logic                  clk_i;
  logic                  rst_ni;
  id2ctrl_t              id2ctrl_i;
  logic                  commit_valid_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic                  commit_kill_i;
  wb2ctrl_t              wb2ctrl_i;
  ctrl2ex_t              ctrl2ex_o;
  ctrl2wb_t              ctrl2wb_o;
  logic [X_ID_MAX-1:0]   free_o;
  logic                  full_o;
  logic [X_ID_WIDTH:0]   outstanding_o;
  logic                  err_o;

  fir_xifu_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .id2ctrl_i      (id2ctrl_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .wb2ctrl_i      (wb2ctrl_i),
    .ctrl2ex_o      (ctrl2ex_o),
    .ctrl2wb_o      (ctrl2wb_o),
    .free_o         (free_o),
    .full_o         (full_o),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] free;
    logic [15:0] ex_commit;
    logic [15:0] wb_issue;
    logic [15:0] wb_commit;
    logic [15:0] wb_kill;
    logic        full;
    logic [4:0]  outstanding;
    logic        err;
  } snap_t;

  snap_t     exp_q[$];
  logic [1:0] m_state [16];   // 0 FREE, 1 ISSUED, 2 COMMITTED, 3 KILLED
  logic       m_err;
  int         n_compared = 0;
  int         n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_state[i] = 2'd0;
    m_err = 1'b0;
  endtask

  // Legal-event formulation: clear legal only when done, issue only when free,
  // commit only when issued or freshly issued this cycle.
  task automatic model_step(input logic iss, input logic [3:0] iid, input logic cv,
                            input logic [3:0] cid, input logic ck, input logic [15:0] clr);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] s, n;
      logic hit_i, hit_c;
      s = m_state[i];
      n = s;
      hit_i = iss && (iid == i[3:0]);
      hit_c = cv && (cid == i[3:0]);
      if (clr[i]) begin
        if (s == 2'd2 || s == 2'd3) n = 2'd0; else m_err = 1'b1;
      end
      if (hit_i) begin
        if (s == 2'd0) n = 2'd1; else m_err = 1'b1;
      end
      if (hit_c) begin
        if (s == 2'd1 || (s == 2'd0 && hit_i)) n = ck ? 2'd3 : 2'd2;
        else m_err = 1'b1;
      end
      m_state[i] = n;
    end
  endtask

  task automatic push_expected();
    snap_t e;
    int cnt;
    e = '0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      e.free[i]      = (m_state[i] == 2'd0);
      e.ex_commit[i] = (m_state[i] == 2'd2);
      e.wb_issue[i]  = (m_state[i] != 2'd0);
      e.wb_commit[i] = (m_state[i] == 2'd2);
      e.wb_kill[i]   = (m_state[i] == 2'd3);
      if (m_state[i] != 2'd0) cnt++;
    end
    e.full        = (cnt == 16);
    e.outstanding = cnt[4:0];
    e.err         = m_err;
    exp_q.push_back(e);
  endtask

  task automatic compare_outputs(input string tag);
    snap_t e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".free"},        32'(free_o),           32'(e.free));
    check({tag, ".ex_commit"},   32'(ctrl2ex_o.commit), 32'(e.ex_commit));
    check({tag, ".wb_issue"},    32'(ctrl2wb_o.issue),  32'(e.wb_issue));
    check({tag, ".wb_commit"},   32'(ctrl2wb_o.commit), 32'(e.wb_commit));
    check({tag, ".wb_kill"},     32'(ctrl2wb_o.kill),   32'(e.wb_kill));
    check({tag, ".full"},        32'(full_o),           32'(e.full));
    check({tag, ".outstanding"}, 32'(outstanding_o),    32'(e.outstanding));
    check({tag, ".err"},         32'(err_o),            32'(e.err));
  endtask

  // Drive one cycle of events; called just after a rising edge.
  task automatic step(input string tag, input logic iss, input logic [3:0] iid,
                      input logic cv, input logic [3:0] cid, input logic ck,
                      input logic [15:0] clr);
    id2ctrl_i.issue = iss;
    id2ctrl_i.id    = iid;
    commit_valid_i  = cv;
    commit_id_i     = cid;
    commit_kill_i   = ck;
    wb2ctrl_i.clear = clr;
    model_step(iss, iid, cv, cid, ck, clr);
    push_expected();
    @(posedge clk_i);
    #1;
    id2ctrl_i       = '0;
    commit_valid_i  = 1'b0;
    commit_id_i     = '0;
    commit_kill_i   = 1'b0;
    wb2ctrl_i       = '0;
    compare_outputs(tag);
  endtask

  // Asynchronous reset away from the clock edge, checked before any edge.
  task automatic do_reset(input string tag);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    push_expected();
    compare_outputs(tag);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni         = 1'b0;
    id2ctrl_i      = '0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    wb2ctrl_i      = '0;
    model_reset();

    // 1. Reset values.
    repeat (2) @(posedge clk_i);
    #1;
    push_expected();
    compare_outputs("reset");
    check("reset.free_const", 32'(free_o), 32'h0000_FFFF);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 2. Issue, commit, clear on id 3.
    step("t2.issue3",  1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 16'h0000);
    check("t2.wb_issue3", 32'(ctrl2wb_o.issue[3]), 32'd1);
    step("t2.commit3", 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 16'h0000);
    check("t2.ex_commit3", 32'(ctrl2ex_o.commit[3]), 32'd1);
    step("t2.clear3",  1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0008);
    check("t2.free3", 32'(free_o[3]), 32'd1);
    check("t2.err", 32'(err_o), 32'd0);

    // 3. Same-cycle issue + kill on id 5, then clear.
    step("t3.issue_kill5", 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 16'h0000);
    check("t3.kill5", 32'(ctrl2wb_o.kill[5]), 32'd1);
    check("t3.commit5", 32'(ctrl2wb_o.commit[5]), 32'd0);
    step("t3.clear5", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0020);

    // 4. Fill every slot, then a duplicate issue on 7.
    for (int i = 0; i < 16; i++) step($sformatf("t4.issue%0d", i), 1'b1, 4'(i), 1'b0, 4'd0, 1'b0, 16'h0000);
    check("t4.full", 32'(full_o), 32'd1);
    check("t4.outstanding", 32'(outstanding_o), 32'd16);
    step("t4.dup7", 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 16'h0000);
    check("t4.err", 32'(err_o), 32'd1);
    check("t4.slot7_issued", 32'({ctrl2wb_o.issue[7], ctrl2wb_o.commit[7], ctrl2wb_o.kill[7]}), 32'b100);

    // 5. Issue on a COMMITTED slot in the same cycle as its clear.
    do_reset("t5.reset");
    step("t5.issue2",  1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 16'h0000);
    step("t5.commit2", 1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 16'h0000);
    check("t5.err_before", 32'(err_o), 32'd0);
    step("t5.clear_issue2", 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 16'h0004);
    check("t5.err", 32'(err_o), 32'd1);
    check("t5.free2", 32'(free_o[2]), 32'd1);
    step("t5.reissue2", 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 16'h0000);
    check("t5.issued2", 32'(ctrl2wb_o.issue[2]), 32'd1);

    // 6. Reset mid-stream with slots 1 and 4 COMMITTED; stale commit afterwards.
    do_reset("t6.reset0");
    step("t6.issue1",  1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 16'h0000);
    step("t6.issue4_commit1", 1'b1, 4'd4, 1'b1, 4'd1, 1'b0, 16'h0000);
    step("t6.commit4", 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 16'h0000);
    check("t6.ex_commit", 32'(ctrl2ex_o.commit), 32'h0012);
    do_reset("t6.midreset");
    check("t6.outstanding", 32'(outstanding_o), 32'd0);
    step("t6.stale_commit1", 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 16'h0000);
    check("t6.err", 32'(err_o), 32'd1);

    // Extra boundary: clear on a FREE slot and on an ISSUED slot are errors.
    do_reset("t7.reset");
    step("t7.clear_free", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h8000);
    do_reset("t7.reset2");
    step("t7.issue15", 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 16'h0000);
    step("t7.clear_issued", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h8000);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
